// File: rtl/data_ram_ctrl_if.sv
// Load/store port bundle between the LSU and the data RAM.
// The master drives requests and the slave returns registered read data.
interface data_ram_ctrl_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10
);
  localparam int LANES = DATA_W / 8;

  logic [ADDR_W-1:0] Addr;
  logic [DATA_W-1:0] Din;
  logic [LANES-1:0]  ByteEn;
  logic              Store;
  logic              Load;
  logic              Clear;
  logic [DATA_W-1:0] Dout;
  logic              Valid;
  logic              Busy;

  modport master (
    output Addr,
    output Din,
    output ByteEn,
    output Store,
    output Load,
    output Clear,
    input  Dout,
    input  Valid,
    input  Busy
  );

  modport slave (
    input  Addr,
    input  Din,
    input  ByteEn,
    input  Store,
    input  Load,
    input  Clear,
    output Dout,
    output Valid,
    output Busy
  );
endinterface

// File: rtl/data_ram_ctrl.sv
// Byte-enabled data RAM with registered read and a sequential clear engine.
// Writes are write-first, so a same-cycle load returns the merged word.
module data_ram_ctrl #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 1024
) (
  input logic          clk,
  input logic          rst_n,
  data_ram_ctrl_if.slave bus
);
  localparam int LANES = DATA_W / 8;
  localparam int PTR_W = ADDR_W + 1;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  if (DATA_W % 8 != 0) begin : g_bad_w
    $error("DATA_W must be a multiple of 8");
  end
  if (DEPTH > (2 ** ADDR_W)) begin : g_bad_d
    $error("DEPTH exceeds address space");
  end

  typedef enum logic {
    IDLE,
    CLEAR
  } state_t;

  state_t state;
  state_t state_nx;

  logic [PTR_W-1:0]  ptr;
  logic [PTR_W-1:0]  ptr_nx;
  logic [DATA_W-1:0] mem [DEPTH];

  logic [IDX_W-1:0]  idx;
  logic              in_range;
  logic [DATA_W-1:0] rd_word;
  logic [DATA_W-1:0] merged;

  logic              we;
  logic [IDX_W-1:0]  waddr;
  logic [DATA_W-1:0] wdata;
  logic              rd_en;
  logic [DATA_W-1:0] dout_nx;

  logic [DATA_W-1:0] dout_q;
  logic              valid_q;
  logic              busy_q;

  assign idx      = IDX_W'(bus.Addr);
  assign in_range = {1'b0, bus.Addr} < PTR_W'(DEPTH);
  assign rd_word  = in_range ? mem[idx] : '0;

  always_comb begin
    merged = rd_word;
    for (int k = 0; k < LANES; k++) begin
      if (bus.ByteEn[k]) begin
        merged[8*k +: 8] = bus.Din[8*k +: 8];
      end
    end
  end

  always_comb begin
    state_nx = state;
    ptr_nx   = ptr;
    we       = 1'b0;
    waddr    = idx;
    wdata    = merged;
    rd_en    = 1'b0;
    dout_nx  = dout_q;
    unique case (state)
      IDLE: begin
        if (bus.Clear) begin
          state_nx = CLEAR;
          ptr_nx   = '0;
        end else begin
          we    = bus.Store & in_range & (|bus.ByteEn);
          rd_en = bus.Load;
          if (bus.Load) begin
            if (!in_range) begin
              dout_nx = '0;
            end else if (bus.Store) begin
              dout_nx = merged;
            end else begin
              dout_nx = rd_word;
            end
          end
        end
      end
      CLEAR: begin
        we     = 1'b1;
        waddr  = IDX_W'(ptr);
        wdata  = '0;
        ptr_nx = ptr + 1'b1;
        // The edge that zeroes the last word also leaves CLEAR.
        if (ptr == PTR_W'(DEPTH - 1)) begin
          state_nx = IDLE;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      ptr     <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state   <= state_nx;
      ptr     <= ptr_nx;
      dout_q  <= dout_nx;
      valid_q <= rd_en;
      busy_q  <= (state_nx == CLEAR);
    end
  end

  assign bus.Dout  = dout_q;
  assign bus.Valid = valid_q;
  assign bus.Busy  = busy_q;
endmodule

// File: tb/tb_data_ram_ctrl.sv
// Bench for data_ram_ctrl: a 16-word and a 20-word instance against
// an array model, plus literal expectations at key points.
module tb_data_ram_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic        st [2];
  logic        ld [2];
  logic        cl [2];
  logic [4:0]  ad [2];
  logic [31:0] di [2];
  logic [3:0]  be [2];

  logic [31:0] q  [2];
  logic        v  [2];
  logic        bz [2];

  data_ram_ctrl_if #(.DATA_W(32), .ADDR_W(4)) b16 ();
  data_ram_ctrl_if #(.DATA_W(32), .ADDR_W(5)) b20 ();

  assign b16.Addr   = ad[0][3:0];
  assign b16.Din    = di[0];
  assign b16.ByteEn = be[0];
  assign b16.Store  = st[0];
  assign b16.Load   = ld[0];
  assign b16.Clear  = cl[0];
  assign q[0]  = b16.Dout;
  assign v[0]  = b16.Valid;
  assign bz[0] = b16.Busy;

  assign b20.Addr   = ad[1];
  assign b20.Din    = di[1];
  assign b20.ByteEn = be[1];
  assign b20.Store  = st[1];
  assign b20.Load   = ld[1];
  assign b20.Clear  = cl[1];
  assign q[1]  = b20.Dout;
  assign v[1]  = b20.Valid;
  assign bz[1] = b20.Busy;

  data_ram_ctrl #(.DATA_W(32), .ADDR_W(4), .DEPTH(16)) u16 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b16)
  );

  data_ram_ctrl #(.DATA_W(32), .ADDR_W(5), .DEPTH(20)) u20 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b20)
  );

  logic [31:0] mm [2][32];
  logic [31:0] md [2];
  logic        mv [2];
  logic        mb [2];
  int          mp [2];

  function automatic int dep(input int i);
    return (i == 0) ? 16 : 20;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] o,
                                        input logic [31:0] d,
                                        input logic [3:0] b);
    logic [31:0] r;
    r = o;
    for (int k = 0; k < 4; k++)
      if (b[k]) r[8*k +: 8] = d[8*k +: 8];
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        md[i] <= 32'h0;
        mv[i] <= 1'b0;
        mb[i] <= 1'b0;
        mp[i] <= 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (mb[i]) begin
          mm[i][mp[i]] <= 32'h0;
          mp[i] <= mp[i] + 1;
          if (mp[i] + 1 == dep(i)) mb[i] <= 1'b0;
          mv[i] <= 1'b0;
        end else if (cl[i]) begin
          mb[i] <= 1'b1;
          mp[i] <= 0;
          mv[i] <= 1'b0;
        end else begin
          if (st[i] && int'(ad[i]) < dep(i))
            mm[i][ad[i]] <= merge(mm[i][ad[i]], di[i], be[i]);
          mv[i] <= ld[i];
          if (ld[i]) begin
            if (int'(ad[i]) >= dep(i)) md[i] <= 32'h0;
            else if (st[i]) md[i] <= merge(mm[i][ad[i]], di[i], be[i]);
            else md[i] <= mm[i][ad[i]];
          end
        end
      end
    end
  end

  task automatic chk(input string nm, input int i,
                     input logic [31:0] a, input logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s[u%0d] t=%0t got %h want %h", nm, i, $time, a, e);
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      chk("dout", i, q[i], md[i]);
      chk("valid", i, 32'(v[i]), 32'(mv[i]));
      chk("busy", i, 32'(bz[i]), 32'(mb[i]));
    end
  end

  task automatic op(input int i, input bit s, input bit l, input bit c,
                    input logic [4:0] a, input logic [31:0] d,
                    input logic [3:0] b);
    st[i] = s; ld[i] = l; cl[i] = c;
    ad[i] = a; di[i] = d; be[i] = b;
    @(posedge clk); #2;
    st[i] = 1'b0; ld[i] = 1'b0; cl[i] = 1'b0;
  endtask

  task automatic wait_idle(input int i);
    int n = 0;
    while (bz[i] && n < 200) begin
      @(posedge clk); #2;
      n++;
    end
    chk("idle_timeout", i, 32'(bz[i]), 32'h0);
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      st[i] = 1'b0; ld[i] = 1'b0; cl[i] = 1'b0;
      ad[i] = 5'd0; di[i] = 32'h0; be[i] = 4'h0;
    end
    #3;
    chk("rst_dout", 0, q[0], 32'h0);
    chk("rst_busy", 0, 32'(bz[0]), 32'h0);
    #20 rst_n = 1'b1;
    @(posedge clk); #2;

    cl[0] = 1'b1; cl[1] = 1'b1;
    @(posedge clk); #2;
    cl[0] = 1'b0; cl[1] = 1'b0;
    wait_idle(0);
    wait_idle(1);

    op(0, 1, 0, 0, 5'd5, 32'hDEADBEEF, 4'hF);
    op(0, 0, 1, 0, 5'd5, 32'h0, 4'h0);
    chk("t1_dout", 0, q[0], 32'hDEADBEEF);
    chk("t1_valid", 0, 32'(v[0]), 32'h1);
    @(posedge clk); #2;
    chk("t1_vdrop", 0, 32'(v[0]), 32'h0);
    chk("t1_hold", 0, q[0], 32'hDEADBEEF);

    op(0, 1, 0, 0, 5'd5, 32'h11223344, 4'b0101);
    op(0, 0, 1, 0, 5'd5, 32'h0, 4'h0);
    chk("t2_merge", 0, q[0], 32'hDE22BE44);

    op(0, 1, 1, 0, 5'd7, 32'hA5A5A5A5, 4'hF);
    chk("t3_wfirst", 0, q[0], 32'hA5A5A5A5);
    chk("t3_valid", 0, 32'(v[0]), 32'h1);
    op(0, 1, 0, 0, 5'd7, 32'hFFFFFFFF, 4'h0);
    op(0, 0, 1, 0, 5'd7, 32'h0, 4'h0);
    chk("be0_keep", 0, q[0], 32'hA5A5A5A5);

    for (int j = 0; j < 16; j++)
      op(0, 1, 0, 0, 5'(j), 32'(j + 1), 4'hF);
    op(0, 1, 0, 1, 5'd3, 32'hFFFFFFFF, 4'hF);
    n = 0;
    while (bz[0] && n < 100) begin
      n++;
      ld[0] = 1'b1;
      ad[0] = 5'(n % 16);
      @(posedge clk); #2;
    end
    ld[0] = 1'b0;
    chk("t4_busy_len", 0, 32'(n), 32'd16);
    chk("t4_novalid", 0, 32'(v[0]), 32'h0);
    for (int j = 0; j < 16; j++) begin
      op(0, 0, 1, 0, 5'(j), 32'h0, 4'h0);
      chk("t4_zero", 0, q[0], 32'h0);
    end

    for (int j = 0; j < 16; j++)
      op(0, 1, 0, 0, 5'(j), 32'(j + 1), 4'hF);
    op(0, 0, 1, 0, 5'd9, 32'h0, 4'h0);
    op(0, 0, 0, 1, 5'd0, 32'h0, 4'h0);
    repeat (6) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("t5_busy", 0, 32'(bz[0]), 32'h0);
    chk("t5_dout", 0, q[0], 32'h0);
    chk("t5_valid", 0, 32'(v[0]), 32'h0);
    #3 rst_n = 1'b1;
    @(posedge clk); #2;
    for (int j = 0; j < 16; j++) begin
      op(0, 0, 1, 0, 5'(j), 32'h0, 4'h0);
      chk("t5_word", 0, q[0], (j < 6) ? 32'h0 : 32'(j + 1));
    end

    op(1, 1, 0, 0, 5'd19, 32'h13131313, 4'hF);
    op(1, 1, 0, 0, 5'd25, 32'hFFFFFFFF, 4'hF);
    op(1, 0, 1, 0, 5'd25, 32'h0, 4'h0);
    chk("t6_oor", 1, q[1], 32'h0);
    chk("t6_oor_valid", 1, 32'(v[1]), 32'h1);
    op(1, 0, 1, 0, 5'd19, 32'h0, 4'h0);
    chk("t6_w19", 1, q[1], 32'h13131313);
    op(1, 1, 1, 0, 5'd19, 32'h0, 4'h0);
    chk("t6_be0_wf", 1, q[1], 32'h13131313);
    op(1, 1, 1, 0, 5'd19, 32'h000000AA, 4'b0001);
    chk("t6_lane0", 1, q[1], 32'h131313AA);

    @(posedge clk); #2;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
